mem_access_unit: RTL and testbench

Multi-cycle load/store controller between the EX stage and data memory in the pipelined CPU. Accepts one memory operation at a time, checks alignment, drives a byte-enabled request to data memory and waits for its acknowledge. Sign/zero-extends load data, then presents the result or an address-error exception to write-back. Replaces the ad-hoc `lh`/`lh_byte` decoding previously spread across the datapath.

---
 rtl/mem_access_unit_if.sv | 39 +++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundle of the EX-side request, data-memory and WB-side result signals of mem_access_unit.
// The slave modport is the unit's view; master is the surrounding pipeline/memory view.
interface mem_access_unit_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [31:0] in_pc;

   logic        mem_req;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rdata;
   logic        out_is_load;
   logic        out_exc;
   logic [4:0]  out_exc_code;
   logic [31:0] out_badvaddr;
   logic [31:0] out_pc;

   modport slave (
      input  in_valid, in_op, in_addr, in_wdata, in_pc, mem_rdata, mem_ack, out_ready,
      output in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
             out_valid, out_rdata, out_is_load, out_exc, out_exc_code, out_badvaddr, out_pc
   );

   modport master (
      output in_valid, in_op, in_addr, in_wdata, in_pc, mem_rdata, mem_ack, out_ready,
      input  in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
             out_valid, out_rdata, out_is_load, out_exc, out_exc_code, out_badvaddr, out_pc
   );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store controller: alignment check, byte-enabled memory request,
// load extension and a registered result/exception toward write-back.
module mem_access_unit (
   input  logic               clk,
   input  logic               reset,
   mem_access_unit_if.slave   bus
);
   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LBU = 3'b001;
   localparam logic [2:0] OP_LH  = 3'b010;
   localparam logic [2:0] OP_LHU = 3'b011;
   localparam logic [2:0] OP_LW  = 3'b100;
   localparam logic [2:0] OP_SB  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SW  = 3'b111;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t      r_state, w_next_state;
   logic [2:0]  r_op;
   logic [1:0]  r_lane;
   logic [31:0] r_pc;
   logic        r_mem_we;
   logic [9:0]  r_mem_addr;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_out_rdata;
   logic        r_out_is_load;
   logic        r_out_exc;
   logic [4:0]  r_out_exc_code;
   logic [31:0] r_out_badvaddr;
   logic [31:0] r_out_pc;

   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic        w_misaligned;
   logic        w_is_store;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_be         = 4'b0000;
      w_wdata      = 32'h0;
      w_misaligned = 1'b0;
      w_is_store   = bus.in_op[2] & (|bus.in_op[1:0]);
      unique case (bus.in_op)
         OP_LB, OP_LBU, OP_SB: begin
            w_be    = 4'b0001 << bus.in_addr[1:0];
            w_wdata = {4{bus.in_wdata[7:0]}};
         end
         OP_LH, OP_LHU, OP_SH: begin
            w_be         = bus.in_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata      = {2{bus.in_wdata[15:0]}};
            w_misaligned = bus.in_addr[0];
         end
         default: begin
            w_be         = 4'b1111;
            w_wdata      = bus.in_wdata;
            w_misaligned = |bus.in_addr[1:0];
         end
      endcase
   end

   // Load extraction works on the lane latched at acceptance, not on the live input address.
   always_comb begin
      w_half      = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      w_byte      = bus.mem_rdata[8*r_lane +: 8];
      w_load_data = 32'h0;
      unique case (r_op)
         OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  w_load_data = {24'h0, w_byte};
         OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
         OP_LHU:  w_load_data = {16'h0, w_half};
         OP_LW:   w_load_data = bus.mem_rdata;
         default: w_load_data = 32'h0;
      endcase
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE: if (bus.in_valid)  w_next_state = w_misaligned ? ST_RESP : ST_WAIT;
         ST_WAIT: if (bus.mem_ack)   w_next_state = ST_RESP;
         ST_RESP: if (bus.out_ready) w_next_state = ST_IDLE;
         default:                    w_next_state = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // NOTE: data registers are reset too, because the outputs must read zero while reset is held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op           <= 3'b000;
         r_lane         <= 2'b00;
         r_pc           <= 32'h0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= 10'h0;
         r_mem_be       <= 4'b0000;
         r_mem_wdata    <= 32'h0;
         r_out_rdata    <= 32'h0;
         r_out_is_load  <= 1'b0;
         r_out_exc      <= 1'b0;
         r_out_exc_code <= 5'd0;
         r_out_badvaddr <= 32'h0;
         r_out_pc       <= 32'h0;
      end else if (r_state == ST_IDLE && bus.in_valid) begin
         r_op   <= bus.in_op;
         r_lane <= bus.in_addr[1:0];
         r_pc   <= bus.in_pc;
         if (w_misaligned) begin
            r_out_rdata    <= 32'h0;
            r_out_is_load  <= 1'b0;
            r_out_exc      <= 1'b1;
            r_out_exc_code <= w_is_store ? 5'd5 : 5'd4;
            r_out_badvaddr <= bus.in_addr;
            r_out_pc       <= bus.in_pc;
         end else begin
            r_mem_we    <= w_is_store;
            r_mem_addr  <= bus.in_addr[11:2];
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
         end
      end else if (r_state == ST_WAIT && bus.mem_ack) begin
         r_out_rdata    <= w_load_data;
         r_out_is_load  <= ~r_mem_we;
         r_out_exc      <= 1'b0;
         r_out_exc_code <= 5'd0;
         r_out_badvaddr <= 32'h0;
         r_out_pc       <= r_pc;
      end
   end

   assign bus.in_ready     = (r_state == ST_IDLE);
   assign bus.mem_req      = (r_state == ST_WAIT);
   assign bus.out_valid    = (r_state == ST_RESP);
   assign bus.mem_we       = r_mem_we;
   assign bus.mem_addr     = r_mem_addr;
   assign bus.mem_be       = r_mem_be;
   assign bus.mem_wdata    = r_mem_wdata;
   assign bus.out_rdata    = r_out_rdata;
   assign bus.out_is_load  = r_out_is_load;
   assign bus.out_exc      = r_out_exc;
   assign bus.out_exc_code = r_out_exc_code;
   assign bus.out_badvaddr = r_out_badvaddr;
   assign bus.out_pc       = r_out_pc;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit: stimulus pushes expected results into a
// scoreboard queue; a monitor pops and compares every retired result.
module tb_mem_access_unit;
   typedef struct packed {
      logic [31:0] rdata;
      logic        is_load;
      logic        exc;
      logic [4:0]  code;
      logic [31:0] badvaddr;
      logic [31:0] pc;
   } resp_t;

   logic clk;
   logic reset;
   mem_access_unit_if bus ();

   mem_access_unit dut (.clk(clk), .reset(reset), .bus(bus));

   resp_t sb_q[$];
   int    n_checks  = 0;
   int    n_errors  = 0;
   int    n_pushed  = 0;
   int    n_retired = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic resp_t mk(input logic [31:0] rdata, input logic is_load, input logic exc,
                                input logic [4:0] code, input logic [31:0] bad, input logic [31:0] pc);
      resp_t r;
      r.rdata = rdata; r.is_load = is_load; r.exc = exc; r.code = code; r.badvaddr = bad; r.pc = pc;
      return r;
   endfunction

   // Monitor: a result retires at the edge following a negedge where valid and ready are both high.
   always @(negedge clk) begin
      if (reset && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_result", {31'b0, bus.out_valid}, 32'h0);
         end else begin
            resp_t e;
            e = sb_q.pop_front();
            n_retired++;
            check("out_rdata",    bus.out_rdata,            e.rdata);
            check("out_is_load",  {31'b0, bus.out_is_load}, {31'b0, e.is_load});
            check("out_exc",      {31'b0, bus.out_exc},     {31'b0, e.exc});
            check("out_exc_code", {27'b0, bus.out_exc_code}, {27'b0, e.code});
            check("out_badvaddr", bus.out_badvaddr,         e.badvaddr);
            check("out_pc",       bus.out_pc,               e.pc);
         end
      end
   end

   task automatic wait_in_ready(input string name);
      int i;
      for (i = 0; i < 20; i++) begin
         if (bus.in_ready) break;
         @(posedge clk); #1;
      end
      if (i == 20) check({name, "_timeout"}, {31'b0, bus.in_ready}, 32'h1);
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] pc, input logic [31:0] rdata, input int ack_dly,
                        input int hold_out, input logic [9:0] e_maddr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input resp_t e_resp);
      logic e_we;
      e_we = (op >= 3'd5);
      wait_in_ready("accept");
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_addr = addr; bus.in_wdata = wdata; bus.in_pc = pc;
      bus.out_ready = (hold_out == 0);
      sb_q.push_back(e_resp);
      n_pushed++;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_addr = 32'hFFFF_FFFF; bus.in_wdata = 32'h5555_5555;
      if (e_resp.exc) begin
         check("exc_no_req",  {31'b0, bus.mem_req},   32'h0);
         check("exc_latency", {31'b0, bus.out_valid}, 32'h1);
      end else begin
         check("req_latency", {31'b0, bus.mem_req}, 32'h1);
         check("mem_we",      {31'b0, bus.mem_we},  {31'b0, e_we});
         check("mem_addr",    {22'b0, bus.mem_addr}, {22'b0, e_maddr});
         check("mem_be",      {28'b0, bus.mem_be},   {28'b0, e_be});
         check("mem_wdata",   bus.mem_wdata,         e_wdata);
         for (int i = 0; i < ack_dly; i++) begin
            @(posedge clk); #1;
            check("wait_req",      {31'b0, bus.mem_req},  32'h1);
            check("wait_mem_addr", {22'b0, bus.mem_addr}, {22'b0, e_maddr});
            check("wait_mem_be",   {28'b0, bus.mem_be},   {28'b0, e_be});
            check("wait_mem_wdata", bus.mem_wdata,        e_wdata);
            check("wait_in_ready", {31'b0, bus.in_ready}, 32'h0);
         end
         bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
         @(posedge clk); #1;
         bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
         check("resp_latency", {31'b0, bus.out_valid}, 32'h1);
         check("resp_no_req",  {31'b0, bus.mem_req},   32'h0);
      end
      for (int i = 0; i < hold_out; i++) begin
         check("hold_valid",    {31'b0, bus.out_valid}, 32'h1);
         check("hold_rdata",    bus.out_rdata,          e_resp.rdata);
         check("hold_pc",       bus.out_pc,             e_resp.pc);
         check("hold_in_ready", {31'b0, bus.in_ready},  32'h0);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      wait_in_ready("retire");
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      bus.in_valid = 1'b0; bus.in_op = 3'b000; bus.in_addr = 32'h0; bus.in_wdata = 32'h0;
      bus.in_pc = 32'h0; bus.mem_rdata = 32'h0; bus.mem_ack = 1'b0; bus.out_ready = 1'b1;
      #1;
      check("rst_mem_req",   {31'b0, bus.mem_req},   32'h0);
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
      check("rst_out_exc",   {31'b0, bus.out_exc},   32'h0);
      check("rst_out_rdata", bus.out_rdata,          32'h0);
      check("rst_mem_be",    {28'b0, bus.mem_be},    32'h0);
      check("rst_out_pc",    bus.out_pc,             32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);

      // Reset in the middle of a request: the transaction must vanish without a result.
      bus.in_valid = 1'b1; bus.in_op = 3'b100; bus.in_addr = 32'h20; bus.in_pc = 32'h400;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("mid_req", {31'b0, bus.mem_req}, 32'h1);
      #3 reset = 1'b0;
      #1;
      check("mid_rst_req_drop", {31'b0, bus.mem_req},   32'h0);
      check("mid_rst_valid",    {31'b0, bus.out_valid}, 32'h0);
      #2 reset = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", {31'b0, bus.in_ready},  32'h1);
      check("post_rst_valid",    {31'b0, bus.out_valid}, 32'h0);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("late_ack_ignored", {31'b0, bus.out_valid}, 32'h0);
         @(posedge clk); #1;
      end

      //    op      addr          wdata         pc            rdata         dly hold maddr   be       mem_wdata     expected result
      do_op(3'b101, 32'h0000_0013, 32'h1234_56AB, 32'h0000_1000, 32'h0,        0, 0, 10'h004, 4'b1000, 32'hABAB_ABAB,
            mk(32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_1000));
      do_op(3'b010, 32'h0000_0102, 32'h0,        32'h0000_1004, 32'h8001_7FFF, 1, 0, 10'h040, 4'b1100, 32'h0,
            mk(32'hFFFF_8001, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0000_1004));
      do_op(3'b011, 32'h0000_0102, 32'h0,        32'h0000_1008, 32'h8001_7FFF, 0, 0, 10'h040, 4'b1100, 32'h0,
            mk(32'h0000_8001, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0000_1008));
      do_op(3'b010, 32'h0000_0100, 32'h0,        32'h0000_100C, 32'h8001_7FFF, 2, 0, 10'h040, 4'b0011, 32'h0,
            mk(32'h0000_7FFF, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0000_100C));
      do_op(3'b000, 32'h0000_0001, 32'h0,        32'h0000_1010, 32'h0000_8000, 0, 0, 10'h000, 4'b0010, 32'h0,
            mk(32'hFFFF_FF80, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0000_1010));
      do_op(3'b001, 32'h0000_0003, 32'h0,        32'h0000_1014, 32'h9A00_0000, 0, 0, 10'h000, 4'b1000, 32'h0,
            mk(32'h0000_009A, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0000_1014));
      do_op(3'b100, 32'h0000_0006, 32'h0,        32'h0000_1018, 32'h0,        0, 0, 10'h000, 4'b0000, 32'h0,
            mk(32'h0, 1'b0, 1'b1, 5'd4, 32'h0000_0006, 32'h0000_1018));
      do_op(3'b110, 32'h0000_0003, 32'h0000_BEEF, 32'h0000_101C, 32'h0,     0, 0, 10'h000, 4'b0000, 32'h0,
            mk(32'h0, 1'b0, 1'b1, 5'd5, 32'h0000_0003, 32'h0000_101C));
      do_op(3'b111, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_1020, 32'h0,     0, 0, 10'h004, 4'b1111, 32'hCAFE_F00D,
            mk(32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_1020));
      do_op(3'b110, 32'h0000_0002, 32'h1234_ABCD, 32'h0000_1024, 32'h0,     0, 0, 10'h000, 4'b1100, 32'hABCD_ABCD,
            mk(32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_1024));
      // Backpressure on both sides: slow memory, then a stalled write-back.
      do_op(3'b100, 32'h0000_0200, 32'h0,        32'h0000_1028, 32'hDEAD_BEEF, 5, 3, 10'h080, 4'b1111, 32'h0,
            mk(32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0000_1028));

      repeat (3) @(posedge clk);
      #1;
      check("retired_count", n_retired, n_pushed);
      check("queue_empty",   sb_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
